// File: rtl/selftest_mailbox.sv
// selftest_mailbox
//   Memory-mapped result port for self-checking 6502 programs. The program
//   writes an expected byte, then the byte it actually computed, and this
//   block tallies checks and mismatches so the test reports its own verdict.
//   A watchdog forces TIMEOUT if a run never signals END.
//
//   Register window (offset from BASE):
//     0 CTRL   (W)  8'h01 = START, 8'h02 = END, other values ignored
//     1 EXPECT (RW) expected byte for the next ACTUAL write
//     2 ACTUAL (W)  byte under test, compared against EXPECT in RUN only
//     3 STATUS (R)  {state[1:0], fail_any, 5'b0}
//
// Ports
//   clk_i          rising-edge clock
//   reset_i        synchronous active-high reset
//   addr_i         CPU address bus
//   wdata_i        CPU write data
//   we_i / re_i    write / read strobes, sampled on the rising edge
//   rdata_o        registered read data, valid the cycle after re_i
//   done_o         high in DONE
//   pass_o         done with no mismatches and at least one check
//   timeout_o      high in TIMEOUT
//   check_count_o  saturating count of ACTUAL writes in the current run
//   fail_count_o   saturating count of mismatches in the current run
//   first_fail_o   check index of the first mismatch, 8'hFF if none
module selftest_mailbox #(
    parameter logic [15:0] BASE    = 16'hE000,
    parameter int          TIMEOUT = 4096,
    parameter int          CW      = 13
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [15:0] addr_i,
    input  logic [7:0]  wdata_i,
    input  logic        we_i,
    input  logic        re_i,
    output logic [7:0]  rdata_o,
    output logic        done_o,
    output logic        pass_o,
    output logic        timeout_o,
    output logic [7:0]  check_count_o,
    output logic [7:0]  fail_count_o,
    output logic [7:0]  first_fail_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUN     = 2'b01,
        DONE    = 2'b10,
        TIMEOUT_ST = 2'b11
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    rdata_q, rdata_d;
    logic [7:0]    expect_q, expect_d;
    logic [7:0]    check_q, check_d;
    logic [7:0]    fail_q, fail_d;
    logic [7:0]    firstFail_q, firstFail_d;
    logic [CW-1:0] watchdog_q, watchdog_d;

    logic [15:0]   offset;
    logic          hit;
    logic [1:0]    regSel;
    logic          wrHit;
    logic          rdHit;
    logic          isStart;
    logic          isEnd;

    // Address decode: subtracting BASE keeps the window correct even if
    // BASE is not 4-byte aligned.
    assign offset  = addr_i - BASE;
    assign hit     = (offset < 16'd4);
    assign regSel  = offset[1:0];
    assign wrHit   = we_i & hit;
    assign rdHit   = re_i & hit;
    assign isStart = wrHit && (regSel == 2'd0) && (wdata_i == 8'h01);
    assign isEnd   = wrHit && (regSel == 2'd0) && (wdata_i == 8'h02);

    // Next-state logic. START is applied last so it overrides the run
    // bookkeeping (watchdog, counters) from any state.
    always_comb begin
        state_d     = state_q;
        rdata_d     = rdata_q;
        expect_d    = expect_q;
        check_d     = check_q;
        fail_d      = fail_q;
        firstFail_d = firstFail_q;
        watchdog_d  = watchdog_q;

        if (wrHit && (regSel == 2'd1)) begin
            expect_d = wdata_i;
        end

        if (state_q == RUN) begin
            watchdog_d = watchdog_q + 1'b1;
            if (wrHit && (regSel == 2'd2)) begin
                check_d = (check_q == 8'hFF) ? 8'hFF : check_q + 8'd1;
                if (wdata_i != expect_q) begin
                    fail_d = (fail_q == 8'hFF) ? 8'hFF : fail_q + 8'd1;
                    if (firstFail_q == 8'hFF) begin
                        firstFail_d = check_q;
                    end
                end
            end
            // END in the expiry cycle still counts as a clean finish.
            if (isEnd) begin
                state_d = DONE;
            end else if (watchdog_q == CW'(TIMEOUT - 1)) begin
                state_d = TIMEOUT_ST;
            end
        end

        if (isStart) begin
            state_d     = RUN;
            check_d     = 8'h00;
            fail_d      = 8'h00;
            firstFail_d = 8'hFF;
            watchdog_d  = '0;
        end

        // Reads use the pre-write register values, so a simultaneous write
        // to the same register returns the old contents.
        if (rdHit) begin
            case (regSel)
                2'd1:    rdata_d = expect_q;
                2'd3:    rdata_d = {state_q, (fail_q != 8'h00), 5'b0};
                default: rdata_d = 8'h00;
            endcase
        end
    end

    // Single state register for the whole block.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            rdata_q     <= 8'h00;
            expect_q    <= 8'h00;
            check_q     <= 8'h00;
            fail_q      <= 8'h00;
            firstFail_q <= 8'hFF;
            watchdog_q  <= '0;
        end else begin
            state_q     <= state_d;
            rdata_q     <= rdata_d;
            expect_q    <= expect_d;
            check_q     <= check_d;
            fail_q      <= fail_d;
            firstFail_q <= firstFail_d;
            watchdog_q  <= watchdog_d;
        end
    end

    assign rdata_o       = rdata_q;
    assign done_o        = (state_q == DONE);
    assign timeout_o     = (state_q == TIMEOUT_ST);
    assign pass_o        = (state_q == DONE) && (fail_q == 8'h00) && (check_q != 8'h00);
    assign check_count_o = check_q;
    assign fail_count_o  = fail_q;
    assign first_fail_o  = firstFail_q;

endmodule

// File: tb/tb_selftest_mailbox.sv
// tb_selftest_mailbox
//   Directed bench for selftest_mailbox. The DUT runs with a shortened
//   watchdog (300 cycles) so the timeout and END-at-expiry cases are quick,
//   while still leaving room for the 260-write saturation run.
module tb_selftest_mailbox;

    localparam logic [15:0] BASE    = 16'hE000;
    localparam int          TIMEOUT = 300;
    localparam int          CW      = 9;

    localparam logic [15:0] CTRL   = BASE + 16'd0;
    localparam logic [15:0] EXPECT = BASE + 16'd1;
    localparam logic [15:0] ACTUAL = BASE + 16'd2;
    localparam logic [15:0] STATUS = BASE + 16'd3;

    logic        clk;
    logic        reset;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        we;
    logic        re;
    logic [7:0]  rdata;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [7:0]  checkCount;
    logic [7:0]  failCount;
    logic [7:0]  firstFail;

    int compareCount = 0;
    int failTotal    = 0;

    selftest_mailbox #(
        .BASE    (BASE),
        .TIMEOUT (TIMEOUT),
        .CW      (CW)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .addr_i        (addr),
        .wdata_i       (wdata),
        .we_i          (we),
        .re_i          (re),
        .rdata_o       (rdata),
        .done_o        (done),
        .pass_o        (pass),
        .timeout_o     (timeout),
        .check_count_o (checkCount),
        .fail_count_o  (failCount),
        .first_fail_o  (firstFail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One bus cycle: drive strobes, let the DUT take the edge, then release
    // 1 time unit later so outputs are sampled away from the edge.
    task automatic applyStimulus(input logic [15:0] a, input logic [7:0] d,
                                 input logic w, input logic r);
        addr  = a;
        wdata = d;
        we    = w;
        re    = r;
        @(posedge clk);
        #1;
        we = 1'b0;
        re = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        assert (observed === expected)
        else begin
            failTotal++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        addr  = 16'h0000;
        wdata = 8'h00;
        we    = 1'b0;
        re    = 1'b0;
        idleCycles(2);
        reset = 1'b0;

        // Reset state
        checkOutput("rst_done",    done,       0);
        checkOutput("rst_pass",    pass,       0);
        checkOutput("rst_timeout", timeout,    0);
        checkOutput("rst_check",   checkCount, 0);
        checkOutput("rst_fail",    failCount,  0);
        checkOutput("rst_first",   firstFail,  8'hFF);
        checkOutput("rst_rdata",   rdata,      0);

        // Single matching check
        applyStimulus(CTRL,   8'h01, 1'b1, 1'b0);
        applyStimulus(EXPECT, 8'h9D, 1'b1, 1'b0);
        applyStimulus(ACTUAL, 8'h9D, 1'b1, 1'b0);
        applyStimulus(CTRL,   8'h02, 1'b1, 1'b0);
        checkOutput("t1_done",  done,       1);
        checkOutput("t1_pass",  pass,       1);
        checkOutput("t1_check", checkCount, 1);
        checkOutput("t1_fail",  failCount,  0);
        checkOutput("t1_first", firstFail,  8'hFF);
        applyStimulus(EXPECT, 8'h00, 1'b0, 1'b1);
        checkOutput("t1_rd_expect", rdata, 8'h9D);
        applyStimulus(STATUS, 8'h00, 1'b0, 1'b1);
        checkOutput("t1_rd_status", rdata, 8'h80);

        // Three checks, second one mismatching
        applyStimulus(CTRL,   8'h01, 1'b1, 1'b0);
        applyStimulus(EXPECT, 8'h10, 1'b1, 1'b0);
        applyStimulus(ACTUAL, 8'h10, 1'b1, 1'b0);
        applyStimulus(ACTUAL, 8'h11, 1'b1, 1'b0);
        checkOutput("t2_mid_check", checkCount, 2);
        checkOutput("t2_mid_fail",  failCount,  1);
        checkOutput("t2_mid_first", firstFail,  1);
        applyStimulus(ACTUAL, 8'h10, 1'b1, 1'b0);
        applyStimulus(CTRL,   8'h02, 1'b1, 1'b0);
        checkOutput("t2_done",  done,       1);
        checkOutput("t2_pass",  pass,       0);
        checkOutput("t2_check", checkCount, 3);
        checkOutput("t2_fail",  failCount,  1);
        checkOutput("t2_first", firstFail,  1);
        applyStimulus(STATUS, 8'h00, 1'b0, 1'b1);
        checkOutput("t2_rd_status", rdata, 8'hA0);

        // Out-of-window write/read and the unencodable CTRL value
        applyStimulus(BASE + 16'd4, 8'h01, 1'b1, 1'b0);
        checkOutput("oow_wr_done",  done, 1);
        applyStimulus(BASE + 16'd4, 8'h00, 1'b0, 1'b1);
        checkOutput("oow_rd_hold",  rdata, 8'hA0);
        applyStimulus(BASE - 16'd1, 8'h00, 1'b0, 1'b1);
        checkOutput("below_rd_hold", rdata, 8'hA0);
        applyStimulus(CTRL, 8'h03, 1'b1, 1'b0);
        checkOutput("ctrl03_done",  done, 1);
        checkOutput("ctrl03_check", checkCount, 3);

        // IDLE: ACTUAL and END have no effect
        reset = 1'b1;
        idleCycles(1);
        reset = 1'b0;
        applyStimulus(ACTUAL, 8'h77, 1'b1, 1'b0);
        checkOutput("idle_act_check", checkCount, 0);
        checkOutput("idle_act_fail",  failCount,  0);
        applyStimulus(CTRL, 8'h02, 1'b1, 1'b0);
        checkOutput("idle_end_done", done, 0);
        applyStimulus(STATUS, 8'h00, 1'b0, 1'b1);
        checkOutput("idle_rd_status", rdata, 8'h00);

        // Saturation of check_count over 260 matching writes
        applyStimulus(CTRL,   8'h01, 1'b1, 1'b0);
        applyStimulus(EXPECT, 8'h55, 1'b1, 1'b0);
        for (int i = 0; i < 260; i++) begin
            applyStimulus(ACTUAL, 8'h55, 1'b1, 1'b0);
        end
        checkOutput("sat_check", checkCount, 8'hFF);
        checkOutput("sat_fail",  failCount,  0);
        applyStimulus(CTRL, 8'h02, 1'b1, 1'b0);
        checkOutput("sat_pass", pass, 1);

        // Watchdog expiry: edge TIMEOUT after the START edge
        applyStimulus(CTRL, 8'h01, 1'b1, 1'b0);
        checkOutput("wd_started_done", done, 0);
        idleCycles(TIMEOUT - 1);
        checkOutput("wd_before", timeout, 0);
        idleCycles(1);
        checkOutput("wd_expired", timeout, 1);
        applyStimulus(CTRL, 8'h02, 1'b1, 1'b0);
        checkOutput("wd_end_ignored_to", timeout, 1);
        checkOutput("wd_end_ignored_dn", done, 0);
        applyStimulus(STATUS, 8'h00, 1'b0, 1'b1);
        checkOutput("wd_rd_status", rdata, 8'hC0);
        applyStimulus(CTRL, 8'h01, 1'b1, 1'b0);
        checkOutput("wd_restart_to", timeout, 0);
        applyStimulus(STATUS, 8'h00, 1'b0, 1'b1);
        checkOutput("wd_restart_status", rdata, 8'h40);

        // END landing on the expiry edge wins
        applyStimulus(CTRL, 8'h01, 1'b1, 1'b0);
        idleCycles(TIMEOUT - 1);
        applyStimulus(CTRL, 8'h02, 1'b1, 1'b0);
        checkOutput("race_done",    done,    1);
        checkOutput("race_timeout", timeout, 0);

        // Reset in the middle of a run with two mismatches
        applyStimulus(CTRL,   8'h01, 1'b1, 1'b0);
        applyStimulus(EXPECT, 8'h01, 1'b1, 1'b0);
        applyStimulus(ACTUAL, 8'h02, 1'b1, 1'b0);
        applyStimulus(ACTUAL, 8'h03, 1'b1, 1'b0);
        checkOutput("mid_fail",  failCount, 2);
        checkOutput("mid_first", firstFail, 0);
        applyStimulus(STATUS, 8'h00, 1'b0, 1'b1);
        checkOutput("mid_rd_status", rdata, 8'h60);
        reset = 1'b1;
        idleCycles(1);
        reset = 1'b0;
        checkOutput("mrst_done",  done,       0);
        checkOutput("mrst_pass",  pass,       0);
        checkOutput("mrst_to",    timeout,    0);
        checkOutput("mrst_check", checkCount, 0);
        checkOutput("mrst_fail",  failCount,  0);
        checkOutput("mrst_first", firstFail,  8'hFF);
        checkOutput("mrst_rdata", rdata,      0);

        // Simultaneous read and write of EXPECT returns the old value
        applyStimulus(EXPECT, 8'hAA, 1'b1, 1'b1);
        checkOutput("rw_old", rdata, 8'h00);
        applyStimulus(EXPECT, 8'h00, 1'b0, 1'b1);
        checkOutput("rw_new", rdata, 8'hAA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failTotal);
        $finish;
    end

endmodule
